// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - Game Boy interrupt controller: IF/IE registers and CPU dispatch handshake
module irq_controller #(
  parameter int         NUM_SRC    = 5,
  parameter logic [7:0] VEC_BASE   = 8'h40,
  parameter logic [7:0] VEC_STRIDE = 8'h08
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ce,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cpu_sel_if,
  input  logic               cpu_sel_ie,
  input  logic               cpu_wr,
  input  logic [7:0]         cpu_di,
  output logic [7:0]         cpu_do,
  output logic               irq_pending,
  input  logic               int_ack,
  output logic [7:0]         int_vector,
  output logic               int_vec_valid
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPATCH = 2'd1;
  localparam logic [1:0] ST_VECTOR   = 2'd2;

  logic [1:0]         state;
  logic [NUM_SRC-1:0] if_r;
  logic [7:0]         ie_r;

  logic [7:0]         ie_wr;
  logic [NUM_SRC-1:0] if_wr;
  logic [NUM_SRC-1:0] pend_m;
  logic [NUM_SRC-1:0] dsp_clr;
  logic [NUM_SRC-1:0] if_next;
  logic [7:0]         vec_sel;

  // Register values as they stand after this edge's CPU writes; dispatch samples these.
  always_comb begin
    ie_wr  = (cpu_wr && cpu_sel_ie) ? cpu_di : ie_r;
    if_wr  = (cpu_wr && cpu_sel_if) ? cpu_di[NUM_SRC-1:0] : if_r;
    pend_m = ie_wr[NUM_SRC-1:0] & if_wr;
  end

  // Scan from lowest priority up so the lowest set bit ends up selected.
  always_comb begin
    dsp_clr = '0;
    vec_sel = 8'h00;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend_m[i]) begin
        dsp_clr    = '0;
        dsp_clr[i] = 1'b1;
        vec_sel    = VEC_BASE + 8'(i) * VEC_STRIDE;
      end
    end
  end

  // Request pulses are OR-ed last so they survive a same-edge write or dispatch clear.
  always_comb begin
    if (state == ST_DISPATCH) begin
      if_next = (if_wr & ~dsp_clr) | irq_src;
    end else begin
      if_next = if_wr | irq_src;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      if_r          <= '0;
      ie_r          <= 8'h00;
      int_vector    <= 8'h00;
      int_vec_valid <= 1'b0;
    end else if (ce) begin
      if_r <= if_next;
      ie_r <= ie_wr;
      case (state)
        ST_IDLE: begin
          int_vec_valid <= 1'b0;
          if (int_ack) begin
            state <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          int_vector    <= vec_sel;
          int_vec_valid <= 1'b1;
          state         <= ST_VECTOR;
        end
        ST_VECTOR: begin
          int_vec_valid <= 1'b0;
          state         <= ST_IDLE;
        end
        default: begin
          int_vec_valid <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    if (cpu_sel_if) begin
      cpu_do = {{(8 - NUM_SRC){1'b1}}, if_r};
    end else if (cpu_sel_ie) begin
      cpu_do = ie_r;
    end else begin
      cpu_do = 8'hFF;
    end
  end

  assign irq_pending = |(ie_r[NUM_SRC-1:0] & if_r);

endmodule
